// File: rtl/dyser_output_bridge.sv
// Drains the DySER per-port output FIFOs round-robin into a single registered
// valid/ready stream to the core, tagging each word with its source port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dyser_output_bridge #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned PORT_ID_W = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS*(`DATA_WIDTH+1)-1:0] fifo_dout,
    input  logic [NUM_PORTS-1:0]                 fifo_empty,
    input  logic [NUM_PORTS-1:0]                 fifo_valid,
    output logic [NUM_PORTS-1:0]                 fifo_deq,
    output logic [`DATA_WIDTH:0]                 core_data,
    output logic [PORT_ID_W-1:0]                 core_port,
    output logic                                 core_valid,
    input  logic                                 core_ready,
    output logic [CNT_W-1:0]                     xfer_count
);

    localparam int unsigned DW = `DATA_WIDTH + 1;

    logic [PORT_ID_W-1:0] ptr;
    logic [PORT_ID_W-1:0] grant;
    logic [PORT_ID_W-1:0] idx;
    logic                 grant_found;
    logic [DW-1:0]        grant_data;
    logic                 can_load;
    logic                 deq_fire;
    logic                 load;
    logic                 drain;

    assign can_load = ~core_valid | core_ready;
    assign drain    = core_valid & core_ready;
    assign deq_fire = grant_found & can_load & ~rst;
    assign load     = deq_fire & fifo_valid[grant];

    // First non-empty port at or after ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            idx = PORT_ID_W'((int'(ptr) + k) % int'(NUM_PORTS));
            if (!grant_found && !fifo_empty[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant == PORT_ID_W'(i)) begin
                grant_data = fifo_dout[i*DW +: DW];
            end
        end
    end

    always_comb begin
        fifo_deq = '0;
        if (deq_fire) begin
            fifo_deq[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_data  <= '0;
            core_port  <= '0;
            xfer_count <= '0;
            ptr        <= '0;
        end else begin
            if (drain) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            // A load overrides the drain so back-to-back words see no bubble.
            if (load) begin
                core_data  <= grant_data;
                core_port  <= grant;
                core_valid <= 1'b1;
                ptr        <= (grant == PORT_ID_W'(NUM_PORTS - 1)) ? '0 : grant + PORT_ID_W'(1);
            end else if (drain) begin
                core_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dyser_output_bridge.sv
// Directed bench for dyser_output_bridge: behavioural FIFO queues feed the DUT,
// each task checks one behaviour against hand-computed values.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dyser_output_bridge;

    localparam int unsigned NP = 5;
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = `DATA_WIDTH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  fifo_dout;
    logic [NP-1:0]     fifo_empty;
    logic [NP-1:0]     fifo_valid;
    logic [NP-1:0]     fifo_deq;
    logic [DW-1:0]     core_data;
    logic [PW-1:0]     core_port;
    logic              core_valid;
    logic              core_ready;
    logic [CW-1:0]     xfer_count;
    logic [NP-1:0]     valid_kill;

    logic [DW-1:0] q [NP][$];
    int checks = 0;
    int passes = 0;

    dyser_output_bridge #(
        .NUM_PORTS (NP),
        .PORT_ID_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_valid (fifo_valid),
        .fifo_deq   (fifo_deq),
        .core_data  (core_data),
        .core_port  (core_port),
        .core_valid (core_valid),
        .core_ready (core_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    assign fifo_valid = fifo_deq & ~fifo_empty & ~valid_kill;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic refresh();
        for (int i = 0; i < int'(NP); i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_dout[i*DW +: DW] = (q[i].size() == 0) ? '0 : q[i][0];
        end
    endtask

    // One clock: sample deq/valid before the edge, pop after it, then settle.
    task automatic tick();
        logic [NP-1:0] deq_s;
        logic [NP-1:0] val_s;
        @(negedge clk);
        deq_s = fifo_deq;
        val_s = fifo_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NP); i++) begin
            if (rst) q[i].delete();
            else if (deq_s[i] && val_s[i]) void'(q[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_kill = '0;
        for (int i = 0; i < int'(NP); i++) q[i].delete();
        refresh();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        core_ready = 1'b1;
        do_reset();
        checks++;
        if (core_data !== '0 || core_port !== '0) begin
            $display("FAIL reset_regs: data=%h port=%0d required 0/0", core_data, core_port);
        end else passes++;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (fifo_deq !== '0 || core_valid !== 1'b0 || xfer_count !== '0) begin
                $display("FAIL reset_idle[%0d]: deq=%b valid=%b cnt=%0d required 0/0/0",
                         c, fifo_deq, core_valid, xfer_count);
            end else passes++;
            tick();
        end
    endtask

    task automatic test_single_port();
        do_reset();
        core_ready = 1'b1;
        q[3].push_back(DW'('hA));
        q[3].push_back(DW'('hB));
        refresh();
        #1;
        checks++;
        if (fifo_deq !== 5'b01000) begin
            $display("FAIL single_deq_t: deq=%b required 01000", fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b1 || core_data !== DW'('hA) || core_port !== 3'd3 ||
            fifo_deq !== 5'b01000) begin
            $display("FAIL single_first: v=%b d=%h p=%0d deq=%b required 1/a/3/01000",
                     core_valid, core_data, core_port, fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b1 || core_data !== DW'('hB) || core_port !== 3'd3 ||
            fifo_deq !== 5'b00000) begin
            $display("FAIL single_second: v=%b d=%h p=%0d deq=%b required 1/b/3/00000",
                     core_valid, core_data, core_port, fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b0 || xfer_count !== 4'd2) begin
            $display("FAIL single_end: v=%b cnt=%0d required 0/2", core_valid, xfer_count);
        end else passes++;
    endtask

    task automatic test_round_robin();
        do_reset();
        core_ready = 1'b1;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < int'(NP); i++) q[i].push_back(DW'(16 * i + j));
        refresh();
        #1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (core_valid !== 1'b1 || core_port !== PW'(k % 5) ||
                core_data !== DW'(16 * (k % 5) + k / 5)) begin
                $display("FAIL rr[%0d]: v=%b p=%0d d=%h required 1/%0d/%h", k, core_valid,
                         core_port, core_data, k % 5, 16 * (k % 5) + k / 5);
            end else passes++;
        end
        tick();
        checks++;
        if (core_valid !== 1'b0 || xfer_count !== 4'd10) begin
            $display("FAIL rr_end: v=%b cnt=%0d required 0/10", core_valid, xfer_count);
        end else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        core_ready = 1'b0;
        q[1].push_back(DW'('h5));
        q[2].push_back(DW'('h7));
        refresh();
        #1;
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (core_valid !== 1'b1 || core_data !== DW'('h5) || core_port !== 3'd1 ||
                fifo_deq !== '0) begin
                $display("FAIL bp_hold[%0d]: v=%b d=%h p=%0d deq=%b required 1/5/1/00000",
                         c, core_valid, core_data, core_port, fifo_deq);
            end else passes++;
            tick();
        end
        core_ready = 1'b1;
        #1;
        checks++;
        if (fifo_deq !== 5'b00100) begin
            $display("FAIL bp_release_deq: deq=%b required 00100", fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b1 || core_data !== DW'('h7) || core_port !== 3'd2 ||
            xfer_count !== 4'd1) begin
            $display("FAIL bp_next: v=%b d=%h p=%0d cnt=%0d required 1/7/2/1",
                     core_valid, core_data, core_port, xfer_count);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b0 || xfer_count !== 4'd2) begin
            $display("FAIL bp_end: v=%b cnt=%0d required 0/2", core_valid, xfer_count);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        core_ready = 1'b1;
        q[0].push_back(DW'('h9));
        q[1].push_back(DW'('h3));
        q[3].push_back(DW'('h33));
        refresh();
        #1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (fifo_deq !== '0) begin
            $display("FAIL midrst_deq: deq=%b required 00000", fifo_deq);
        end else passes++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (core_valid !== 1'b0 || xfer_count !== '0 || core_data !== '0 || core_port !== '0) begin
            $display("FAIL midrst_regs: v=%b cnt=%0d d=%h p=%0d required 0/0/0/0",
                     core_valid, xfer_count, core_data, core_port);
        end else passes++;
        q[1].push_back(DW'('h11));
        q[4].push_back(DW'('h44));
        refresh();
        #1;
        checks++;
        if (fifo_deq !== 5'b00010) begin
            $display("FAIL midrst_ptr: deq=%b required 00010", fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_port !== 3'd1 || core_data !== DW'('h11)) begin
            $display("FAIL midrst_first: p=%0d d=%h required 1/11", core_port, core_data);
        end else passes++;
        tick();
        tick();
    endtask

    task automatic test_protocol_error();
        do_reset();
        core_ready = 1'b1;
        q[2].push_back(DW'('h2A));
        q[3].push_back(DW'('h3B));
        valid_kill = 5'b00100;
        refresh();
        #1;
        checks++;
        if (fifo_deq !== 5'b00100) begin
            $display("FAIL perr_deq: deq=%b required 00100", fifo_deq);
        end else passes++;
        tick();
        valid_kill = '0;
        #1;
        checks++;
        if (core_valid !== 1'b0 || fifo_deq !== 5'b00100) begin
            $display("FAIL perr_noload: v=%b deq=%b required 0/00100", core_valid, fifo_deq);
        end else passes++;
        tick();
        checks++;
        if (core_valid !== 1'b1 || core_data !== DW'('h2A) || core_port !== 3'd2) begin
            $display("FAIL perr_retry: v=%b d=%h p=%0d required 1/2a/2",
                     core_valid, core_data, core_port);
        end else passes++;
        tick();
        checks++;
        if (core_data !== DW'('h3B) || core_port !== 3'd3) begin
            $display("FAIL perr_next: d=%h p=%0d required 3b/3", core_data, core_port);
        end else passes++;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        core_ready = 1'b1;
        for (int j = 0; j < 17; j++) q[0].push_back(DW'(j));
        refresh();
        #1;
        for (int n = 0; n < 16; n++) tick();
        checks++;
        if (xfer_count !== 4'd15 || core_data !== DW'(15)) begin
            $display("FAIL wrap_pre: cnt=%0d d=%h required 15/f", xfer_count, core_data);
        end else passes++;
        tick();
        checks++;
        if (xfer_count !== 4'd0 || core_valid !== 1'b1) begin
            $display("FAIL wrap: cnt=%0d v=%b required 0/1", xfer_count, core_valid);
        end else passes++;
        tick();
        checks++;
        if (xfer_count !== 4'd1 || core_valid !== 1'b0) begin
            $display("FAIL wrap_post: cnt=%0d v=%b required 1/0", xfer_count, core_valid);
        end else passes++;
    endtask

    initial begin
        rst = 1'b1;
        core_ready = 1'b0;
        valid_kill = '0;
        fifo_empty = '1;
        fifo_dout = '0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_protocol_error();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
